// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_pkg
// Description : Shared state encoding and default widths for the fetch stage,
//               instruction register and instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

  localparam int DEF_NBIT   = 16;
  localparam int DEF_ADDR_W = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

endpackage : instr_fetch_pkg
`default_nettype wire

// File: rtl/instr_fetch_pc.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc
// Description : Program counter register with increment-with-wrap and
//               direct target load; load takes priority over increment.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else if (load) begin
      r_pc <= target;
    end else if (inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign pc = r_pc;

endmodule : fetch_pc
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetch stage: req/ack instruction read, one-cycle load strobe
//               to the instruction register, branch redirect, halt, timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                nBit     = DEF_NBIT,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [nBit-1:0]   mem_rdata,
  output logic [nBit-1:0]   control_word,
  output logic              instruct_load,
  input  logic              exec_done,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt_req,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fetch_err
);

  localparam int                 c_CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);

  logic [2:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [nBit-1:0]    r_control_word;
  logic               r_fetch_err;
  logic               w_pc_inc;
  logic               w_pc_load;

  // The increment lands in S_LOAD, so a branch in S_EXEC simply overwrites it.
  assign w_pc_inc  = (r_state == S_LOAD);
  assign w_pc_load = (r_state == S_EXEC) && exec_done && branch_en;

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk    (clk),
    .reset  (reset),
    .inc    (w_pc_inc),
    .load   (w_pc_load),
    .target (branch_target),
    .pc     (pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_control_word <= '0;
      r_fetch_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!stall) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
          end
        end
        S_FETCH: begin
          // An ack in the timeout cycle still completes the fetch.
          if (mem_ack) begin
            r_control_word <= mem_rdata;
            r_state        <= S_LOAD;
          end else if (r_cnt == c_TIMEOUT) begin
            r_fetch_err <= 1'b1;
            r_state     <= S_HALT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (exec_done) begin
            if (halt_req) begin
              r_state <= S_HALT;
            end else if (stall) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_FETCH;
              r_cnt   <= '0;
            end
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req       = (r_state == S_FETCH);
  assign instruct_load = (r_state == S_LOAD);
  assign halted        = (r_state == S_HALT);
  assign mem_addr      = pc;
  assign control_word  = r_control_word;
  assign fetch_err     = r_fetch_err;

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch with a simple
//               programmable-latency instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] control_word;
  logic        instruct_load;
  logic        exec_done = 1'b0;
  logic        branch_en = 1'b0;
  logic [7:0]  branch_target = '0;
  logic        halt_req = 1'b0;
  logic        stall = 1'b0;
  logic [7:0]  pc;
  logic        halted;
  logic        fetch_err;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [256];
  int          ack_delay = 0;
  logic        ack_never = 1'b0;
  int          wcnt = 0;

  instr_fetch #(
    .nBit     (16),
    .ADDR_W   (8),
    .RESET_PC (8'h00),
    .TIMEOUT  (15)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .control_word  (control_word),
    .instruct_load (instruct_load),
    .exec_done     (exec_done),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .stall         (stall),
    .pc            (pc),
    .halted        (halted),
    .fetch_err     (fetch_err)
  );

  always #5 clk = ~clk;

  // Memory answers on the falling edge, ack_delay cycles after req is seen.
  always @(negedge clk) begin
    if (mem_req && !ack_never) begin
      if (wcnt == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        wcnt      = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt    = wcnt + 1;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  typedef struct {
    logic        stall;
    logic        ed;
    logic        br;
    logic        hlt_rq;
    logic [7:0]  tgt;
    logic        e_req;
    logic [7:0]  e_addr;
    logic        e_il;
    logic [15:0] e_cw;
    logic [7:0]  e_pc;
    logic        e_halted;
    logic        e_ferr;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    mem[8'h00] = 16'h1234;
    mem[8'h01] = 16'h5678;
    mem[8'hFF] = 16'hABCD;
    mem[8'h40] = 16'h4040;

    //          stall ed br hlt tgt     req addr   il cw        pc     hl fe
    tbl[0]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, 1'b1,8'h00, 1'b0,16'h0000, 8'h00, 1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b1,16'h1234, 8'h00, 1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,8'h01, 1'b0,16'h1234, 8'h01, 1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, 1'b1,8'h01, 1'b0,16'h1234, 8'h01, 1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,8'h01, 1'b1,16'h5678, 8'h01, 1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,8'h02, 1'b0,16'h5678, 8'h02, 1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b1,1'b1,1'b0,8'hFF, 1'b1,8'hFF, 1'b0,16'h5678, 8'hFF, 1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,8'hFF, 1'b1,16'hABCD, 8'hFF, 1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b0,16'hABCD, 8'h00, 1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b1,1'b0,8'h40, 1'b1,8'h40, 1'b0,16'hABCD, 8'h40, 1'b0,1'b0};
    tbl[10] = '{1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,8'h40, 1'b1,16'h4040, 8'h40, 1'b0,1'b0};
    tbl[11] = '{1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,8'h41, 1'b0,16'h4040, 8'h41, 1'b0,1'b0};
    tbl[12] = '{1'b0,1'b0,1'b1,1'b1,8'h77, 1'b0,8'h41, 1'b0,16'h4040, 8'h41, 1'b0,1'b0};
    tbl[13] = '{1'b0,1'b1,1'b1,1'b1,8'h20, 1'b0,8'h20, 1'b0,16'h4040, 8'h20, 1'b1,1'b0};
    tbl[14] = '{1'b0,1'b1,1'b0,1'b0,8'h00, 1'b0,8'h20, 1'b0,16'h4040, 8'h20, 1'b1,1'b0};

    #1;
    reset = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_il", 32'(instruct_load), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_cw", 32'(control_word), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_ferr", 32'(fetch_err), 32'd0);
    step();
    reset = 1'b1;

    // Zero-wait run, wrap from 8'hFF, branch, ignored branch, halt with branch.
    for (int i = 0; i < 15; i++) begin
      stall         = tbl[i].stall;
      exec_done     = tbl[i].ed;
      branch_en     = tbl[i].br;
      halt_req      = tbl[i].hlt_rq;
      branch_target = tbl[i].tgt;
      step();
      chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(tbl[i].e_req));
      chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("v%0d_il", i), 32'(instruct_load), 32'(tbl[i].e_il));
      chk($sformatf("v%0d_cw", i), 32'(control_word), 32'(tbl[i].e_cw));
      chk($sformatf("v%0d_pc", i), 32'(pc), 32'(tbl[i].e_pc));
      chk($sformatf("v%0d_halted", i), 32'(halted), 32'(tbl[i].e_halted));
      chk($sformatf("v%0d_ferr", i), 32'(fetch_err), 32'(tbl[i].e_ferr));
    end

    // Wait states: ack on the fifth FETCH cycle.
    exec_done = 1'b0; branch_en = 1'b0; halt_req = 1'b0; stall = 1'b0;
    ack_delay = 4;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("ws%0d_mem_req", i), 32'(mem_req), 32'd1);
      chk($sformatf("ws%0d_addr", i), 32'(mem_addr), 32'd0);
      chk($sformatf("ws%0d_il", i), 32'(instruct_load), 32'd0);
    end
    step();
    chk("ws_load", 32'(instruct_load), 32'd1);
    chk("ws_cw", 32'(control_word), 32'h1234);
    step();
    chk("ws_single_pulse", 32'(instruct_load), 32'd0);
    chk("ws_ferr", 32'(fetch_err), 32'd0);
    chk("ws_pc", 32'(pc), 32'd1);

    // Stall at exec_done parks in IDLE; fetch resumes one cycle after release.
    stall = 1'b1; exec_done = 1'b1;
    step();
    chk("st_idle_req", 32'(mem_req), 32'd0);
    exec_done = 1'b0;
    step();
    chk("st_hold_req", 32'(mem_req), 32'd0);
    stall = 1'b0;
    step();
    chk("st_resume_req", 32'(mem_req), 32'd1);
    chk("st_resume_addr", 32'(mem_addr), 32'd1);

    // Asynchronous reset in the middle of the fetch.
    step();
    reset = 1'b0;
    #1;
    chk("ar_mem_req", 32'(mem_req), 32'd0);
    chk("ar_pc", 32'(pc), 32'd0);
    chk("ar_cw", 32'(control_word), 32'd0);
    chk("ar_il", 32'(instruct_load), 32'd0);
    chk("ar_halted", 32'(halted), 32'd0);
    step();
    reset = 1'b1;

    // Timeout: no ack ever; 16 FETCH cycles then error and halt.
    ack_never = 1'b1;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("to%0d_mem_req", i), 32'(mem_req), 32'd1);
      chk($sformatf("to%0d_ferr", i), 32'(fetch_err), 32'd0);
    end
    step();
    chk("to_ferr", 32'(fetch_err), 32'd1);
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_mem_req", 32'(mem_req), 32'd0);
    ack_never = 1'b0;
    exec_done = 1'b1;
    step();
    step();
    chk("to_stay_halted", 32'(halted), 32'd1);
    chk("to_stay_req", 32'(mem_req), 32'd0);
    chk("to_sticky_ferr", 32'(fetch_err), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_instr_fetch
`default_nettype wire
